// File: rtl/tx_packet_arbiter_pkg.sv
// Shared types for the UART TX packet arbiter: packet beat layout, arbiter state
// and the saturating drop-counter helper.
package Structures;

    localparam int unsigned MAX_SRC = 4;
    localparam int unsigned GRANT_W = 2;
    localparam int unsigned TMR_W   = 10;
    localparam int unsigned DROP_W  = 8;
    localparam int unsigned CNT_W   = 3;

    typedef struct packed {
        logic       Valid;
        logic       SoP;
        logic       EoP;
        logic [1:0] Source;
        logic [1:0] Destination;
        logic [7:0] Length;
        logic [7:0] Data;
    } UART_PACKET;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_e;

    function automatic logic [DROP_W-1:0] sat_add(input logic [DROP_W-1:0] a,
                                                  input logic [CNT_W-1:0]  b);
        logic [DROP_W:0] sum;
        sum = {1'b0, a} + (DROP_W+1)'(b);
        return sum[DROP_W] ? {DROP_W{1'b1}} : sum[DROP_W-1:0];
    endfunction

endpackage

// File: rtl/tx_packet_arbiter_rr_select.sv
// Round-robin picker: first requester after the last served index, wrapping.
module rr_select
    import Structures::*;
#(
    parameter int unsigned NUM_SRC = 2
) (
    input  logic [NUM_SRC-1:0] req_i,
    input  logic [GRANT_W-1:0] last_i,
    output logic [GRANT_W-1:0] winner_o,
    output logic               any_o
);

    logic [MAX_SRC-1:0] req_pad;
    int unsigned        idx;

    always_comb begin
        req_pad  = MAX_SRC'(req_i);
        idx      = 0;
        winner_o = '0;
        any_o    = 1'b0;
        for (int unsigned i = 1; i <= NUM_SRC; i++) begin
            idx = (32'(last_i) + i) % NUM_SRC;
            if (!any_o && req_pad[GRANT_W'(idx)]) begin
                winner_o = GRANT_W'(idx);
                any_o    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/tx_packet_arbiter.sv
// Merges packet streams from NUM_SRC sources onto one UART transmitter, one whole
// packet at a time, draining orphan beats and aborting stalled packets.
module tx_packet_arbiter
    import Structures::*;
#(
    parameter int unsigned NUM_SRC = 2,
    parameter int unsigned TIMEOUT = 1023
) (
    input  logic                      ipClk,
    input  logic                      ipReset,
    input  UART_PACKET [NUM_SRC-1:0]  ipStream,
    output logic [NUM_SRC-1:0]        opReady,
    input  logic                      ipTxReady,
    output UART_PACKET                opTxStream,
    output logic [GRANT_W-1:0]        opGrant,
    output logic                      opTimeout,
    output logic [DROP_W-1:0]         opDropCount
);

    logic                     rst_q;
    arb_state_e               state_q, state_d;
    logic [GRANT_W-1:0]       grant_q, grant_d;
    logic [GRANT_W-1:0]       last_q,  last_d;
    logic [TMR_W-1:0]         tmr_q,   tmr_d;
    logic [DROP_W-1:0]        drop_q,  drop_d;
    logic                     tout_q,  tout_d;

    logic [NUM_SRC-1:0]       req;
    logic [NUM_SRC-1:0]       drain;
    UART_PACKET [MAX_SRC-1:0] stream_pad;
    UART_PACKET               granted;
    logic [GRANT_W-1:0]       winner;
    logic                     any_req;
    logic                     xfer;

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
        assign req[g]     = ipStream[g].Valid &  ipStream[g].SoP;
        assign drain[g]   = ipStream[g].Valid & ~ipStream[g].SoP;
        assign opReady[g] = ~rst_q & ((state_q == BUSY) ?
                                      (ipTxReady & (grant_q == GRANT_W'(g))) : drain[g]);
    end

    for (genvar g = 0; g < MAX_SRC; g++) begin : g_pad
        if (g < NUM_SRC) begin : g_on
            assign stream_pad[g] = ipStream[g];
        end else begin : g_off
            assign stream_pad[g] = '0;
        end
    end

    rr_select #(.NUM_SRC(NUM_SRC)) u_rr_select (
        .req_i    (req),
        .last_i   (last_q),
        .winner_o (winner),
        .any_o    (any_req)
    );

    // Reset is retimed once so it lands one edge after ipReset is seen.
    always_ff @(posedge ipClk) begin
        rst_q <= ipReset;
        if (rst_q) begin
            state_q <= IDLE;
            grant_q <= GRANT_W'(NUM_SRC - 1);
            last_q  <= GRANT_W'(NUM_SRC - 1);
            tmr_q   <= '0;
            drop_q  <= '0;
            tout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            tmr_q   <= tmr_d;
            drop_q  <= drop_d;
            tout_q  <= tout_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        last_d     = last_q;
        tmr_d      = tmr_q;
        drop_d     = drop_q;
        tout_d     = 1'b0;
        opTxStream = '0;
        granted    = stream_pad[grant_q];
        xfer       = 1'b0;
        case (state_q)
            IDLE: begin
                drop_d = sat_add(drop_q, CNT_W'($countones(drain)));
                if (any_req) begin
                    grant_d = winner;
                    tmr_d   = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                opTxStream = granted;
                xfer       = granted.Valid & ipTxReady;
                if (xfer) begin
                    tmr_d = '0;
                    if (granted.EoP) begin
                        state_d = IDLE;
                        last_d  = grant_q;
                    end
                end else if (tmr_q == TMR_W'(TIMEOUT - 1)) begin
                    // Stalled packet: abort and let the next source in rotation go.
                    tmr_d   = '0;
                    tout_d  = 1'b1;
                    state_d = IDLE;
                    last_d  = grant_q;
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        if (rst_q) begin
            opTxStream.Valid = 1'b0;
        end
    end

    assign opGrant     = grant_q;
    assign opTimeout   = tout_q;
    assign opDropCount = drop_q;

endmodule

// File: tb/tb_tx_packet_arbiter.sv
// Directed and randomized checks of tx_packet_arbiter against a cycle-level
// reference model of the arbitration rules.
module tb_tx_packet_arbiter;
    import Structures::*;

    localparam int unsigned NS = 2;
    localparam int unsigned TO = 8;
    localparam int unsigned SW = $clog2(NS);

    logic                clk = 1'b0;
    logic                rst;
    UART_PACKET [NS-1:0] stream;
    logic [NS-1:0]       ready;
    logic                txr;
    UART_PACKET          txs;
    logic [1:0]          grant;
    logic                tout;
    logic [7:0]          drop;

    tx_packet_arbiter #(.NUM_SRC(NS), .TIMEOUT(TO)) dut (
        .ipClk       (clk),
        .ipReset     (rst),
        .ipStream    (stream),
        .opReady     (ready),
        .ipTxReady   (txr),
        .opTxStream  (txs),
        .opGrant     (grant),
        .opTimeout   (tout),
        .opDropCount (drop)
    );

    always #5 clk = ~clk;

    int         n_cmp = 0;
    int         n_bad = 0;
    UART_PACKET srcq[NS][$];
    UART_PACKET outq[$];
    bit         en[NS];
    int         vprob;
    int         txmode;
    int         cyc = 0;
    int         first_out_cyc;
    int         n_tout;

    // reference model state
    bit m_rst, m_busy, m_tout;
    int m_owner, m_last, m_idle, m_drop;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        for (int s = 0; s < NS; s++) begin
            if (srcq[s].size() > 0 && en[s] && $urandom_range(99) < vprob) begin
                stream[SW'(s)]       = srcq[s][0];
                stream[SW'(s)].Valid = 1'b1;
            end else begin
                stream[SW'(s)] = '0;
            end
        end
        case (txmode)
            0:       txr = 1'b1;
            1:       txr = ~txr;
            default: txr = 1'($urandom_range(1));
        endcase
    endtask

    task automatic cycle();
        bit         xf[NS];
        bit         found;
        int         nd;
        logic       e;
        UART_PACKET cur;
        @(negedge clk);
        for (int s = 0; s < NS; s++) begin
            if (m_rst)       e = 1'b0;
            else if (m_busy) e = (s == m_owner) ? txr : 1'b0;
            else             e = stream[SW'(s)].Valid & ~stream[SW'(s)].SoP;
            chk($sformatf("ready%0d", s), 64'(ready[SW'(s)]), 64'(e));
            xf[s] = stream[SW'(s)].Valid & ready[SW'(s)];
        end
        cur = stream[SW'(m_owner)];
        e   = !m_rst && m_busy && cur.Valid;
        chk("tx_valid", 64'(txs.Valid), 64'(e));
        if (e) chk("tx_beat", 64'(txs), 64'(cur));
        chk("grant", 64'(grant), 64'(m_owner));
        chk("timeout", 64'(tout), 64'(m_tout));
        chk("drop_count", 64'(drop), 64'(m_drop));
        if (tout) n_tout++;
        if (txs.Valid && txr) begin
            if (outq.size() == 0) first_out_cyc = cyc;
            outq.push_back(txs);
        end
        // model advance for the coming edge
        if (m_rst) begin
            m_busy = 0; m_owner = NS - 1; m_last = NS - 1; m_idle = 0; m_drop = 0; m_tout = 0;
        end else if (!m_busy) begin
            m_tout = 0;
            nd     = 0;
            for (int s = 0; s < NS; s++)
                if (stream[SW'(s)].Valid && !stream[SW'(s)].SoP) nd++;
            m_drop = (m_drop + nd > 255) ? 255 : m_drop + nd;
            found  = 0;
            for (int k = 1; k <= NS; k++) begin
                int c;
                c = (m_last + k) % NS;
                if (!found && stream[SW'(c)].Valid && stream[SW'(c)].SoP) begin
                    found   = 1;
                    m_owner = c;
                end
            end
            if (found) begin m_busy = 1; m_idle = 0; end
        end else begin
            m_tout = 0;
            if (cur.Valid && txr) begin
                m_idle = 0;
                if (cur.EoP) begin m_busy = 0; m_last = m_owner; end
            end else if (m_idle + 1 >= TO) begin
                m_busy = 0; m_last = m_owner; m_tout = 1; m_idle = 0;
            end else begin
                m_idle++;
            end
        end
        m_rst = rst;
        @(posedge clk);
        #1;
        cyc++;
        for (int s = 0; s < NS; s++)
            if (xf[s]) void'(srcq[s].pop_front());
        drive();
    endtask

    task automatic run(input int n);
        repeat (n) cycle();
    endtask

    task automatic run_until_empty(input string tag, input int limit);
        int n;
        n = 0;
        while ((srcq[0].size() + srcq[1].size()) > 0 && n < limit) begin
            cycle();
            n++;
        end
        chk(tag, 64'(srcq[0].size() + srcq[1].size()), 64'(0));
    endtask

    task automatic push_pkt(input int s, input int len, input logic [7:0] base);
        UART_PACKET b;
        for (int i = 0; i < len; i++) begin
            b             = '0;
            b.Valid       = 1'b1;
            b.SoP         = (i == 0);
            b.EoP         = (i == len - 1);
            b.Source      = 2'(s);
            b.Destination = 2'($urandom_range(3));
            b.Length      = 8'(len);
            b.Data        = 8'(base + 8'(i));
            srcq[s].push_back(b);
        end
    endtask

    task automatic push_rand(input int s);
        UART_PACKET b;
        int r, len;
        r = $urandom_range(9);
        if (r == 0) begin
            b        = '0;
            b.Valid  = 1'b1;
            b.EoP    = 1'($urandom_range(1));
            b.Source = 2'(s);
            b.Data   = 8'($urandom_range(255));
            srcq[s].push_back(b);
        end else begin
            len = $urandom_range(1, 6);
            for (int i = 0; i < len; i++) begin
                b             = '0;
                b.Valid       = 1'b1;
                b.SoP         = (i == 0) || (r == 1 && i == 1 && len > 2);
                b.EoP         = (i == len - 1);
                b.Source      = 2'(s);
                b.Destination = 2'($urandom_range(3));
                b.Length      = 8'(len);
                b.Data        = 8'($urandom_range(255));
                srcq[s].push_back(b);
            end
        end
    endtask

    task automatic do_reset();
        for (int s = 0; s < NS; s++) begin
            srcq[s].delete();
            en[s] = 1'b1;
        end
        vprob  = 100;
        txmode = 0;
        rst    = 1'b1;
        drive();
        run(2);
        rst = 1'b0;
        run(2);
        outq.delete();
    endtask

    initial begin
        int nsop, viol, cur_src, nxf;
        int sop_src[$];
        rst    = 1'b1;
        stream = '0;
        txr    = 1'b1;
        for (int s = 0; s < NS; s++) en[s] = 1'b1;
        vprob  = 100;
        txmode = 0;
        repeat (2) @(posedge clk);
        #1;
        m_rst = 1; m_busy = 0; m_owner = NS - 1; m_last = NS - 1;
        m_idle = 0; m_drop = 0; m_tout = 0;
        // reset state, held and released
        run(2);
        rst = 1'b0;
        run(2);

        // single 4-beat packet from source 0
        outq.delete();
        push_pkt(0, 4, 8'hA1);
        drive();
        begin
            int start;
            start = cyc;
            run(8);
            chk("t1_latency", 64'(first_out_cyc - start), 64'(1));
        end
        chk("t1_beats", 64'(outq.size()), 64'(4));
        for (int i = 0; i < 4; i++)
            if (i < outq.size()) chk("t1_data", 64'(outq[i].Data), 64'(8'hA1 + 8'(i)));
        chk("t1_grant", 64'(grant), 64'(0));

        // both sources contending from reset: strict alternation, no interleaving
        do_reset();
        push_pkt(0, 3, 8'h10); push_pkt(0, 3, 8'h20);
        push_pkt(1, 3, 8'h30); push_pkt(1, 3, 8'h40);
        drive();
        run_until_empty("t2_drain", 100);
        run(3);
        nsop = 0; viol = 0; cur_src = -1;
        sop_src.delete();
        foreach (outq[i]) begin
            if (outq[i].SoP) begin
                sop_src.push_back(int'(outq[i].Source));
                cur_src = int'(outq[i].Source);
            end else if (int'(outq[i].Source) != cur_src) viol++;
        end
        chk("t2_packets", 64'(sop_src.size()), 64'(4));
        for (int i = 0; i < 4; i++)
            if (i < sop_src.size()) chk("t2_order", 64'(sop_src[i]), 64'(i % 2));
        chk("t2_interleave", 64'(viol), 64'(0));

        // back-pressure toggling every cycle
        outq.delete();
        txmode = 1;
        push_pkt(0, 4, 8'hB1);
        drive();
        run(10);
        txmode = 0;
        chk("t3_beats", 64'(outq.size()), 64'(4));
        for (int i = 0; i < 4; i++)
            if (i < outq.size()) chk("t3_data", 64'(outq[i].Data), 64'(8'hB1 + 8'(i)));

        // source 0 stalls mid-packet; source 1 waits and takes over after abort
        outq.delete();
        n_tout = 0;
        push_pkt(0, 4, 8'hC1);
        void'(srcq[0].pop_back());
        void'(srcq[0].pop_back());
        en[1] = 1'b0;
        push_pkt(1, 2, 8'hD1);
        drive();
        run(2);
        en[1] = 1'b1;
        run(18);
        chk("t4_pulses", 64'(n_tout), 64'(1));
        chk("t4_grant", 64'(grant), 64'(1));
        chk("t4_src1_done", 64'(srcq[1].size()), 64'(0));

        // 300 orphan beats while idle saturate the drop counter
        for (int i = 0; i < 300; i++) begin
            UART_PACKET b;
            b        = '0;
            b.Valid  = 1'b1;
            b.Source = 2'd1;
            b.Data   = 8'(i);
            srcq[1].push_back(b);
        end
        drive();
        run_until_empty("t5_drain", 400);
        run(1);
        chk("t5_drop_sat", 64'(drop), 64'(8'hFF));

        // reset in the middle of a packet
        n_tout = 0;
        push_pkt(0, 10, 8'hE0);
        drive();
        run(4);
        rst = 1'b1;
        run(2);
        #2;
        chk("t6_valid", 64'(txs.Valid), 64'(0));
        chk("t6_grant", 64'(grant), 64'(NS - 1));
        chk("t6_timeout", 64'(n_tout + int'(tout)), 64'(0));
        srcq[0].delete();
        drive();
        run(1);
        rst = 1'b0;
        run(2);

        // randomized traffic
        do_reset();
        vprob  = 85;
        txmode = 2;
        repeat (40) begin
            for (int s = 0; s < NS; s++)
                while (srcq[s].size() < 4) push_rand(s);
            run(30);
        end
        vprob = 100;
        run_until_empty("rand_drain", 400);
        nxf = outq.size();
        chk("rand_progress", 64'(nxf > 0), 64'(1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
